// File: rtl/kasumi_fo_round.sv
// Iterative KASUMI FO function: a single FI stage is reused across the three FO sub-rounds.
// Result appears three edges after acceptance and is held until out_ready.
module kasumi_fo_round #(
   parameter int unsigned NUM_ROUNDS = 3,
   parameter int unsigned CNT_W      = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [47:0] ko,
   input  logic [47:0] ki,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_ROUNDS - 1);

   localparam int unsigned S7 [128] = '{
       54,  50,  62,  56,  22,  34,  94,  96,  38,   6,  63,  93,   2,  18, 123,  33,
       55, 113,  39, 114,  21,  67,  65,  12,  47,  73,  46,  27,  25, 111, 124,  81,
       53,   9, 121,  79,  52,  60,  58,  48, 101, 127,  40, 120, 104,  70,  71,  43,
       20, 122,  72,  61,  23, 109,  13, 100,  77,   1,  16,   7,  82,  10, 105,  98,
      117, 116,  76,  11,  89, 106,   0, 125, 118,  99,  86,  69,  30,  57, 126,  87,
      112,  51,  17,   5,  95,  14,  90,  84,  91,   8,  35, 103,  32,  97,  28,  66,
      102,  31,  26,  45,  75,   4,  85,  92,  37,  74,  80,  49,  68,  29, 115,  44,
       64, 107, 108,  24, 110,  83,  36,  78,  42,  19,  15,  41,  88, 119,  59,   3
   };

   localparam int unsigned S9 [512] = '{
      167, 239, 161, 379, 391, 334,   9, 338,  38, 226,  48, 358, 452, 385,  90, 397,
      183, 253, 147, 331, 415, 340,  51, 362, 306, 500, 262,  82, 216, 159, 356, 177,
      175, 241, 489,  37, 206,  17,   0, 333,  44, 254, 378,  58, 143, 220,  81, 400,
       95,   3, 315, 245,  54, 235, 218, 405, 472, 264, 172, 494, 371, 290, 399,  76,
      165, 197, 395, 121, 257, 480, 423, 212, 240,  28, 462, 176, 406, 507, 288, 223,
      501, 407, 249, 265,  89, 186, 221, 428, 164,  74, 440, 196, 458, 421, 350, 163,
      232, 158, 134, 354,  13, 250, 491, 142, 191,  69, 193, 425, 152, 227, 366, 135,
      344, 300, 276, 242, 437, 320, 113, 278,  11, 243,  87, 317,  36,  93, 496,  27,
      487, 446, 482,  41,  68, 156, 457, 131, 326, 403, 339,  20,  39, 115, 442, 124,
      475, 384, 508,  53, 112, 170, 479, 151, 126, 169,  73, 268, 279, 321, 168, 364,
      363, 292,  46, 499, 393, 327, 324,  24, 456, 267, 157, 460, 488, 426, 309, 229,
      439, 506, 208, 271, 349, 401, 434, 236,  16, 209, 359,  52,  56, 120, 199, 277,
      465, 416, 252, 287, 246,   6,  83, 305, 420, 345, 153, 502,  65,  61, 244, 282,
      173, 222, 418,  67, 386, 368, 261, 101, 476, 291, 195, 430,  49,  79, 166, 330,
      280, 383, 373, 128, 382, 408, 155, 495, 367, 388, 274, 107, 459, 417,  62, 454,
      132, 225, 203, 316, 234,  14, 301,  91, 503, 286, 424, 211, 347, 307, 140, 374,
       35, 103, 125, 427,  19, 214, 453, 146, 498, 314, 444, 230, 256, 329, 198, 285,
       50, 116,  78, 410,  10, 205, 510, 171, 231,  45, 139, 467,  29,  86, 505,  32,
       72,  26, 342, 150, 313, 490, 431, 238, 411, 325, 149, 473,  40, 119, 174, 355,
      185, 233, 389,  71, 448, 273, 372,  55, 110, 178, 322,  12, 469, 392, 369, 190,
        1, 109, 375, 137, 181,  88,  75, 308, 260, 484,  98, 272, 370, 275, 412, 111,
      336, 318,   4, 504, 492, 259, 304,  77, 337, 435,  21, 357, 303, 332, 483,  18,
       47,  85,  25, 497, 474, 289, 100, 269, 296, 478, 270, 106,  31, 104, 433,  84,
      414, 486, 394,  96,  99, 154, 511, 148, 413, 361, 409, 255, 162, 215, 302, 201,
      266, 351, 343, 144, 441, 365, 108, 298, 251,  34, 182, 509, 138, 210, 335, 133,
      311, 352, 328, 141, 396, 346, 123, 319, 450, 281, 429, 228, 443, 481,  92, 404,
      485, 422, 248, 297,  23, 213, 130, 466,  22, 217, 283,  70, 294, 360, 419, 127,
      312, 377,   7, 468, 194,   2, 117, 295, 463, 258, 224, 447, 247, 187,  80, 398,
      284, 353, 105, 390, 299, 471, 470, 184,  57, 200, 348,  63, 204, 188,  33, 451,
       97,  30, 310, 219,  94, 160, 129, 493,  64, 179, 263, 102, 189, 207, 114, 402,
      438, 477, 387, 122, 192,  42, 381,   5, 145, 118, 180, 449, 293, 323, 136, 380,
       43,  66,  60, 455, 341, 445, 202, 432,   8, 237,  15, 376, 436, 464,  59, 461
   };

   function automatic logic [6:0] s7(input logic [6:0] x);
      return 7'(S7[x]);
   endfunction

   function automatic logic [8:0] s9(input logic [8:0] x);
      return 9'(S9[x]);
   endfunction

   typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [15:0]       l_q, r_q;
   logic [47:0]       ko_q, ki_q;
   logic [31:0]       out_q;

   logic              can_accept, accept, step, last;
   logic [15:0]       ko_sel, ki_sel;
   logic [15:0]       fi_in, fi_out;
   logic [8:0]        fi_r1, fi_l2, fi_r3;
   logic [6:0]        fi_r2, fi_l4;

   // can_accept excludes rst_n so the reset net stays out of the flop data paths
   assign can_accept = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign accept     = in_valid && can_accept;
   assign step       = (state_q == StRound) && (cnt_q <= LastCnt);
   assign last       = (state_q == StRound) && (cnt_q == LastCnt);

   always_comb begin
      ko_sel = ko_q[47:32];
      ki_sel = ki_q[47:32];
      case (cnt_q)
         CNT_W'(0): begin
            ko_sel = ko_q[15:0];
            ki_sel = ki_q[15:0];
         end
         CNT_W'(1): begin
            ko_sel = ko_q[31:16];
            ki_sel = ki_q[31:16];
         end
         default: ;
      endcase
   end

   // FI: 9/7-bit unbalanced Feistel, KI1 = ki_sel[15:9], KI2 = ki_sel[8:0]
   always_comb begin
      fi_in  = l_q ^ ko_sel;
      fi_r1  = s9(fi_in[15:7]) ^ {2'b00, fi_in[6:0]};
      fi_l2  = fi_r1 ^ ki_sel[8:0];
      fi_r2  = s7(fi_in[6:0]) ^ fi_r1[6:0] ^ ki_sel[15:9];
      fi_r3  = s9(fi_l2) ^ {2'b00, fi_r2};
      fi_l4  = s7(fi_r2) ^ fi_r3[6:0];
      fi_out = {fi_l4, fi_r3};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StRound;
         end
         StRound: begin
            if (cnt_q > LastCnt)       state_d = StIdle;
            else if (cnt_q == LastCnt) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = in_valid ? StRound : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && can_accept;
      busy      = (state_q == StRound);
      out_valid = (state_q == StDone);
      out_data  = out_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         l_q   <= '0;
         r_q   <= '0;
         ko_q  <= '0;
         ki_q  <= '0;
         out_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
         l_q   <= in_data[31:16];
         r_q   <= in_data[15:0];
         ko_q  <= ko;
         ki_q  <= ki;
      end else if (step) begin
         l_q   <= r_q;
         r_q   <= fi_out ^ r_q;
         cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
         if (last) out_q <= {r_q, fi_out ^ r_q};
      end
   end

endmodule

// File: tb/tb_kasumi_fo_round.sv
// Directed + randomized bench for kasumi_fo_round against an arithmetic FO/FI reference.
module tb_kasumi_fo_round;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] in_data, out_data;
   logic [47:0] ko, ki;

   int checks   = 0;
   int failures = 0;

   kasumi_fo_round dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .ko        (ko),
      .ki        (ki),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   localparam int unsigned S7_TAB [128] = '{
       54,  50,  62,  56,  22,  34,  94,  96,  38,   6,  63,  93,   2,  18, 123,  33,
       55, 113,  39, 114,  21,  67,  65,  12,  47,  73,  46,  27,  25, 111, 124,  81,
       53,   9, 121,  79,  52,  60,  58,  48, 101, 127,  40, 120, 104,  70,  71,  43,
       20, 122,  72,  61,  23, 109,  13, 100,  77,   1,  16,   7,  82,  10, 105,  98,
      117, 116,  76,  11,  89, 106,   0, 125, 118,  99,  86,  69,  30,  57, 126,  87,
      112,  51,  17,   5,  95,  14,  90,  84,  91,   8,  35, 103,  32,  97,  28,  66,
      102,  31,  26,  45,  75,   4,  85,  92,  37,  74,  80,  49,  68,  29, 115,  44,
       64, 107, 108,  24, 110,  83,  36,  78,  42,  19,  15,  41,  88, 119,  59,   3
   };

   localparam int unsigned S9_TAB [512] = '{
      167, 239, 161, 379, 391, 334,   9, 338,  38, 226,  48, 358, 452, 385,  90, 397,
      183, 253, 147, 331, 415, 340,  51, 362, 306, 500, 262,  82, 216, 159, 356, 177,
      175, 241, 489,  37, 206,  17,   0, 333,  44, 254, 378,  58, 143, 220,  81, 400,
       95,   3, 315, 245,  54, 235, 218, 405, 472, 264, 172, 494, 371, 290, 399,  76,
      165, 197, 395, 121, 257, 480, 423, 212, 240,  28, 462, 176, 406, 507, 288, 223,
      501, 407, 249, 265,  89, 186, 221, 428, 164,  74, 440, 196, 458, 421, 350, 163,
      232, 158, 134, 354,  13, 250, 491, 142, 191,  69, 193, 425, 152, 227, 366, 135,
      344, 300, 276, 242, 437, 320, 113, 278,  11, 243,  87, 317,  36,  93, 496,  27,
      487, 446, 482,  41,  68, 156, 457, 131, 326, 403, 339,  20,  39, 115, 442, 124,
      475, 384, 508,  53, 112, 170, 479, 151, 126, 169,  73, 268, 279, 321, 168, 364,
      363, 292,  46, 499, 393, 327, 324,  24, 456, 267, 157, 460, 488, 426, 309, 229,
      439, 506, 208, 271, 349, 401, 434, 236,  16, 209, 359,  52,  56, 120, 199, 277,
      465, 416, 252, 287, 246,   6,  83, 305, 420, 345, 153, 502,  65,  61, 244, 282,
      173, 222, 418,  67, 386, 368, 261, 101, 476, 291, 195, 430,  49,  79, 166, 330,
      280, 383, 373, 128, 382, 408, 155, 495, 367, 388, 274, 107, 459, 417,  62, 454,
      132, 225, 203, 316, 234,  14, 301,  91, 503, 286, 424, 211, 347, 307, 140, 374,
       35, 103, 125, 427,  19, 214, 453, 146, 498, 314, 444, 230, 256, 329, 198, 285,
       50, 116,  78, 410,  10, 205, 510, 171, 231,  45, 139, 467,  29,  86, 505,  32,
       72,  26, 342, 150, 313, 490, 431, 238, 411, 325, 149, 473,  40, 119, 174, 355,
      185, 233, 389,  71, 448, 273, 372,  55, 110, 178, 322,  12, 469, 392, 369, 190,
        1, 109, 375, 137, 181,  88,  75, 308, 260, 484,  98, 272, 370, 275, 412, 111,
      336, 318,   4, 504, 492, 259, 304,  77, 337, 435,  21, 357, 303, 332, 483,  18,
       47,  85,  25, 497, 474, 289, 100, 269, 296, 478, 270, 106,  31, 104, 433,  84,
      414, 486, 394,  96,  99, 154, 511, 148, 413, 361, 409, 255, 162, 215, 302, 201,
      266, 351, 343, 144, 441, 365, 108, 298, 251,  34, 182, 509, 138, 210, 335, 133,
      311, 352, 328, 141, 396, 346, 123, 319, 450, 281, 429, 228, 443, 481,  92, 404,
      485, 422, 248, 297,  23, 213, 130, 466,  22, 217, 283,  70, 294, 360, 419, 127,
      312, 377,   7, 468, 194,   2, 117, 295, 463, 258, 224, 447, 247, 187,  80, 398,
      284, 353, 105, 390, 299, 471, 470, 184,  57, 200, 348,  63, 204, 188,  33, 451,
       97,  30, 310, 219,  94, 160, 129, 493,  64, 179, 263, 102, 189, 207, 114, 402,
      438, 477, 387, 122, 192,  42, 381,   5, 145, 118, 180, 449, 293, 323, 136, 380,
       43,  66,  60, 455, 341, 445, 202, 432,   8, 237,  15, 376, 436, 464,  59, 461
   };

   // FI as four Feistel half-rounds on integers (left 9 bits / right 7 bits)
   function automatic int unsigned ref_fi(input int unsigned x, input int unsigned k);
      int unsigned l, r, t;
      l = x >> 7;
      r = x & 'h7f;
      t = S9_TAB[l] ^ r;                            l = r;                  r = t;
      t = S7_TAB[l] ^ (r & 'h7f) ^ (k >> 9);        l = r ^ (k & 'h1ff);    r = t;
      t = S9_TAB[l] ^ r;                            l = r;                  r = t;
      l = S7_TAB[l] ^ (r & 'h7f);
      return (l << 9) | r;
   endfunction

   function automatic logic [31:0] ref_fo(input logic [31:0] d, input logic [47:0] k_o,
                                          input logic [47:0] k_i);
      int unsigned l, r, t;
      l = 32'(d[31:16]);
      r = 32'(d[15:0]);
      for (int j = 0; j < 3; j++) begin
         t = ref_fi(l ^ 32'(k_o[16*j +: 16]), 32'(k_i[16*j +: 16])) ^ r;
         l = r;
         r = t;
      end
      return {16'(l), 16'(r)};
   endfunction

   function automatic logic [47:0] rnd48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[47:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One block with out_ready high; optionally scramble inputs while it computes.
   task automatic run_block(input string tag, input logic [31:0] d, input logic [47:0] k_o,
                            input logic [47:0] k_i, input bit scramble);
      logic [31:0] exp;
      exp       = ref_fo(d, k_o, k_i);
      in_data   = d;
      ko        = k_o;
      ki        = k_i;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 check({tag, ":ready_idle"}, 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check({tag, ":busy0"}, 32'(busy), 1);
      check({tag, ":noready0"}, 32'(in_ready), 0);
      for (int i = 1; i <= 3; i++) begin
         if (scramble) begin
            in_data = $urandom();
            ko      = rnd48();
            ki      = rnd48();
         end
         tick();
         if (i < 3) begin
            check({tag, ":busy"}, 32'(busy), 1);
            check({tag, ":early_valid"}, 32'(out_valid), 0);
         end else begin
            check({tag, ":valid"}, 32'(out_valid), 1);
            check({tag, ":busy_done"}, 32'(busy), 0);
            check({tag, ":data"}, out_data, exp);
         end
      end
      tick();
      check({tag, ":idle_valid"}, 32'(out_valid), 0);
      check({tag, ":idle_data"}, out_data, exp);
   endtask

   logic [31:0] d_a, d_b;
   logic [47:0] ko_a, ki_a, ko_b, ki_b;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = $urandom();
      ko        = rnd48();
      ki        = rnd48();

      #3;
      check("rst:in_ready", 32'(in_ready), 0);
      check("rst:out_valid", 32'(out_valid), 0);
      check("rst:busy", 32'(busy), 0);
      check("rst:out_data", out_data, 0);
      tick();
      tick();
      check("rst:held_busy", 32'(busy), 0);
      in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("post_rst:in_ready", 32'(in_ready), 1);
      check("post_rst:out_valid", 32'(out_valid), 0);

      run_block("basic", 32'h0123_4567, 48'h0, 48'h0, 1'b0);
      run_block("zero", 32'h0, 48'h0, 48'h0, 1'b0);
      run_block("hold", $urandom(), rnd48(), rnd48(), 1'b1);

      // Back-to-back with in_valid and out_ready held high
      d_a = 32'hFEDC_BA98; ko_a = rnd48(); ki_a = rnd48();
      d_b = 32'h7654_3210; ko_b = rnd48(); ki_b = rnd48();
      in_data = d_a; ko = ko_a; ki = ki_a; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_data = d_b; ko = ko_b; ki = ki_b;
      tick();
      tick();
      check("b2b:a_early", 32'(out_valid), 0);
      tick();
      check("b2b:a_valid", 32'(out_valid), 1);
      check("b2b:a_data", out_data, ref_fo(d_a, ko_a, ki_a));
      check("b2b:a_ready", 32'(in_ready), 1);
      tick();
      check("b2b:b_busy", 32'(busy), 1);
      check("b2b:b_nvalid", 32'(out_valid), 0);
      in_valid = 1'b0;
      tick();
      tick();
      check("b2b:b_early", 32'(out_valid), 0);
      tick();
      check("b2b:b_valid", 32'(out_valid), 1);
      check("b2b:b_data", out_data, ref_fo(d_b, ko_b, ki_b));
      tick();
      check("b2b:idle", 32'(out_valid), 0);

      // Backpressure: hold result for 10 cycles while a new block waits
      d_a = $urandom(); ko_a = rnd48(); ki_a = rnd48();
      d_b = $urandom(); ko_b = rnd48(); ki_b = rnd48();
      in_data = d_a; ko = ko_a; ki = ki_a; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_data = d_b; ko = ko_b; ki = ki_b;
      tick();
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         check("bp:valid", 32'(out_valid), 1);
         check("bp:data", out_data, ref_fo(d_a, ko_a, ki_a));
         check("bp:no_ready", 32'(in_ready), 0);
         tick();
      end
      check("bp:still_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      #1 check("bp:release_ready", 32'(in_ready), 1);
      tick();
      check("bp:accepted", 32'(busy), 1);
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("bp:b_valid", 32'(out_valid), 1);
      check("bp:b_data", out_data, ref_fo(d_b, ko_b, ki_b));
      tick();

      // Async reset after one sub-round discards the block in flight
      in_data = $urandom(); ko = rnd48(); ki = rnd48(); in_valid = 1'b1; out_ready = 1'b1;
      tick();
      tick();
      check("ar:busy_before", 32'(busy), 1);
      #1 rst_n = 1'b0;
      #1;
      check("ar:busy", 32'(busy), 0);
      check("ar:out_valid", 32'(out_valid), 0);
      check("ar:out_data", out_data, 0);
      check("ar:in_ready", 32'(in_ready), 0);
      tick();
      tick();
      in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ar:no_output", 32'(out_valid), 0);
         check("ar:idle_busy", 32'(busy), 0);
      end
      run_block("after_rst", $urandom(), rnd48(), rnd48(), 1'b1);

      for (int n = 0; n < 6; n++) begin
         run_block("rand", $urandom(), rnd48(), rnd48(), 1'(n % 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kasumi_fo_round.md
Name: kasumi_fo_round

Overview:
- Iterative KASUMI FO function. Consumes the 16-bit FI stage: one internal FO_stage instance is time-multiplexed across the three FO sub-rounds.
- Accepts a 32-bit FO input plus the round's KO/KI subkeys through a valid/ready handshake. Produces a 32-bit FO output three clock cycles after acceptance.
- Sits between the FL/round-control logic and the FI stage in the KASUMI datapath.

Parameters:
- NUM_ROUNDS, 3, number of FI sub-rounds. 3 is the only value legal for KASUMI; other values exist for bench use only.
- CNT_W, 2, width of the sub-round counter. Must satisfy 2^CNT_W > NUM_ROUNDS-1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/ko/ki valid.
- in_ready  output  1  block can accept a new input this cycle.
- in_data  input  32  FO input. L0=in_data[31:16], R0=in_data[15:0].
- ko  input  48  KO subkeys. KO1=ko[15:0], KO2=ko[31:16], KO3=ko[47:32].
- ki  input  48  KI subkeys. KI1=ki[15:0], KI2=ki[31:16], KI3=ki[47:32].
- out_valid  output  1  out_data holds a finished FO result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  32  FO output {L3,R3}.
- busy  output  1  high in ROUND state.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; counter = 0.
  - L, R, latched ko/ki and out_data = 0.
  - out_valid = 0, busy = 0.
  - in_ready is forced to 0 while rst_n is low.
  - Reset asserted mid-ROUND or in DONE discards the block in flight. No output is ever produced for it.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch L<=in_data[31:16], R<=in_data[15:0], ko, ki; counter<=0; go to ROUND.
  - ROUND: in_ready=0, busy=1. Per edge, with j = counter+1:
    - R <= FI(L, KOj, KIj) ^ R, where the FI stage XORs KOj internally.
    - L <= old R.
    - counter increments.
    - When counter == NUM_ROUNDS-1, the update is applied and the state goes to DONE.
  - DONE: out_valid=1, out_data={L,R}, stable until accepted. in_ready = out_ready.
    - out_valid&out_ready with in_valid=1: accept the new block in the same edge and go to ROUND (back-to-back).
    - out_valid&out_ready with in_valid=0: go to IDLE.
- Latency and throughput:
  - Accept edge at cycle 0 → out_valid high after edge 3.
  - Sustained throughput is one block per 4 cycles with out_ready held high.
- FI inputs are driven from the registered L and the latched key slices selected by counter. Only one FI instance exists.
- Latched keys and state are ignored against later changes on ko/ki/in_data until the next accept.
- Backpressure: out_ready low in DONE holds out_data/out_valid indefinitely. in_valid during that time is not accepted.
- in_valid in ROUND is ignored; the source must hold it until in_ready.
- The counter never wraps past NUM_ROUNDS-1. An illegal counter value forces IDLE.
- out_data is updated only on the transition into DONE. It keeps its last value in IDLE.

Test Plan:
- Reset, then in_data=0x0123_4567, ko=0x0, ki=0x0, in_valid pulse, out_ready=1 → out_valid rises exactly 3 edges after accept; out_data equals the C golden FO model for these values.
- Zero-key structural check: with ko=ki=0 and in_data=0x0000_0000 → out_data = FO_golden(0); busy high for exactly 3 cycles; in_ready low during those cycles.
- Back-to-back: two blocks 0xFEDC_BA98 and 0x7654_3210 with random 48-bit ko/ki, in_valid and out_ready held high → outputs 4 cycles apart, both matching golden, in order.
- Backpressure: out_ready=0 for 10 cycles after DONE → out_valid stays 1 and out_data is constant; in_valid=1 during the stall is not accepted (in_ready=0); release → block accepted the same edge.
- Input hold: change ko/ki/in_data every cycle during ROUND → result equals golden on the values present at the accept edge.
- Async reset: assert rst_n low in ROUND after 1 sub-round → outputs clear immediately without a clock; after release, no out_valid until a new accept; the next block computes correctly.
